// File: rtl/dma_pkg.sv
// Shared types and helpers for the NASTI burst data mover: FSM state encoding,
// NASTI response/burst constants and the burst-length planner.
package dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_WR_RESP
  } dma_state_t;

  localparam logic [1:0] NASTI_RESP_OKAY = 2'b00;
  localparam logic [1:0] BURST_INCR      = 2'b01;

  // Beats for the next burst: capped by max_burst, remaining data and the 4KB page of both ends.
  function automatic logic [8:0] burst_beats(input logic [63:0] src, input logic [63:0] dst,
                                             input logic [63:0] rem, input int unsigned max_burst,
                                             input int unsigned size_log2);
    logic [63:0] lim;
    logic [63:0] s_lim;
    logic [63:0] d_lim;
    logic [63:0] r_lim;
    r_lim = rem >> size_log2;
    s_lim = (64'h1000 - (src & 64'hFFF)) >> size_log2;
    d_lim = (64'h1000 - (dst & 64'hFFF)) >> size_log2;
    lim   = 64'(max_burst);
    if (r_lim < lim) lim = r_lim;
    if (s_lim < lim) lim = s_lim;
    if (d_lim < lim) lim = d_lim;
    return (lim > 64'd256) ? 9'd256 : lim[8:0];
  endfunction

endpackage

// File: rtl/nasti_channel.sv
// NASTI (AXI4) channel bundle: AR/R/AW/W/B with master and slave views.
interface nasti_channel #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 1
);
  logic                    arvalid, arready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize, arprot;
  logic [1:0]              arburst;
  logic [ID_WIDTH-1:0]     arid;
  logic [3:0]              arcache, arqos, arregion;
  logic                    aruser;

  logic                    rvalid, rready, rlast;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic [ID_WIDTH-1:0]     rid;

  logic                    awvalid, awready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize, awprot;
  logic [1:0]              awburst;
  logic [ID_WIDTH-1:0]     awid;
  logic [3:0]              awcache, awqos, awregion;
  logic                    awuser;

  logic                    wvalid, wready, wlast, wuser;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;

  logic                    bvalid, bready;
  logic [1:0]              bresp;
  logic [ID_WIDTH-1:0]     bid;

  modport master (
    output arvalid, araddr, arlen, arsize, arprot, arburst, arid, arcache, arqos, arregion, aruser,
    input  arready,
    input  rvalid, rlast, rdata, rresp, rid,
    output rready,
    output awvalid, awaddr, awlen, awsize, awprot, awburst, awid, awcache, awqos, awregion, awuser,
    input  awready,
    output wvalid, wlast, wuser, wdata, wstrb,
    input  wready,
    input  bvalid, bresp, bid,
    output bready
  );

  modport slave (
    input  arvalid, araddr, arlen, arsize, arprot, arburst, arid, arcache, arqos, arregion, aruser,
    output arready,
    output rvalid, rlast, rdata, rresp, rid,
    input  rready,
    input  awvalid, awaddr, awlen, awsize, awprot, awburst, awid, awcache, awqos, awregion, awuser,
    output awready,
    input  wvalid, wlast, wuser, wdata, wstrb,
    output wready,
    output bvalid, bresp, bid,
    input  bready
  );
endinterface

// File: rtl/dma_beat_fifo.sv
// Show-ahead beat buffer between the read and write halves of a burst.
module dma_beat_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == (AW + 1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge aclk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/nasti_dma_mover.sv
// NASTI burst data mover: reads each burst into a local buffer, then writes it out.
// Define DMA_MOVER_ERR_EN to flag non-OKAY responses and beat-count errors on err.
module nasti_dma_mover
  import dma_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int MAX_BURST  = 16,
  parameter int ID_WIDTH   = 1
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dest_addr,
  input  logic [ADDR_WIDTH-1:0] length,
  output logic                  done,
  output logic                  err,
  nasti_channel.master          m
);
  localparam int BYTES     = DATA_WIDTH / 8;
  localparam int SIZE_LOG2 = $clog2(BYTES);

  dma_state_t            state;
  logic [ADDR_WIDTH-1:0] src, dest, remaining;
  logic [ADDR_WIDTH-1:0] step, nxt_src, nxt_dest, nxt_rem;
  logic [8:0]            beats, rd_count, wr_count, plan_beats;
  logic                  arvalid_q, awvalid_q, rready_q, bready_q, done_q, err_q;
  logic                  push, pop, full, empty, wvalid, wlast, r_bad, b_bad;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  unused;

  assign step     = ADDR_WIDTH'(beats) << SIZE_LOG2;
  assign nxt_src  = src + step;
  assign nxt_dest = dest + step;
  assign nxt_rem  = remaining - step;

  // The planner sees the job inputs when starting, else the post-burst addresses.
  always_comb begin
    plan_beats = '0;
    if (state == ST_IDLE)
      plan_beats = burst_beats(src_addr, dest_addr, length, MAX_BURST, SIZE_LOG2);
    else
      plan_beats = burst_beats(nxt_src, nxt_dest, nxt_rem, MAX_BURST, SIZE_LOG2);
  end

  assign push   = rready_q & m.rvalid;
  assign wvalid = (state == ST_WR_DATA) & ~empty;
  assign pop    = wvalid & m.wready;
  assign wlast  = (wr_count == beats - 9'd1);

`ifdef DMA_MOVER_ERR_EN
  assign r_bad  = (m.rresp != NASTI_RESP_OKAY) | (m.rlast & ((rd_count + 9'd1) != beats));
  assign b_bad  = (m.bresp != NASTI_RESP_OKAY);
  assign unused = ^{m.rid, m.bid, full};
`else
  assign r_bad  = 1'b0;
  assign b_bad  = 1'b0;
  assign unused = ^{m.rid, m.bid, m.rresp, m.bresp, full};
`endif

  dma_beat_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(MAX_BURST)) u_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .push    (push),
    .pop     (pop),
    .din     (m.rdata),
    .dout    (fifo_dout),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= ST_IDLE;
      src       <= '0;
      dest      <= '0;
      remaining <= '0;
      beats     <= '0;
      rd_count  <= '0;
      wr_count  <= '0;
      arvalid_q <= 1'b0;
      awvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      bready_q  <= 1'b0;
      done_q    <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // done low while idle only after a zero-length job; release it next cycle.
          if (!done_q) begin
            done_q <= 1'b1;
          end else if (en) begin
            src       <= src_addr;
            dest      <= dest_addr;
            remaining <= length;
            beats     <= plan_beats;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            if (length != '0) begin
              arvalid_q <= 1'b1;
              state     <= ST_RD_ADDR;
            end
          end
        end
        ST_RD_ADDR: if (m.arready) begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b1;
          rd_count  <= '0;
          state     <= ST_RD_DATA;
        end
        ST_RD_DATA: if (m.rvalid) begin
          rd_count <= rd_count + 9'd1;
          if (r_bad) err_q <= 1'b1;
          if (m.rlast) begin
            rready_q  <= 1'b0;
            awvalid_q <= 1'b1;
            state     <= ST_WR_ADDR;
          end
        end
        ST_WR_ADDR: if (m.awready) begin
          awvalid_q <= 1'b0;
          wr_count  <= '0;
          state     <= ST_WR_DATA;
        end
        ST_WR_DATA: if (pop) begin
          wr_count <= wr_count + 9'd1;
          if (wlast) begin
            bready_q <= 1'b1;
            state    <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: if (m.bvalid) begin
          bready_q  <= 1'b0;
          src       <= nxt_src;
          dest      <= nxt_dest;
          remaining <= nxt_rem;
          if (b_bad) err_q <= 1'b1;
          if (nxt_rem == '0 || err_q || b_bad) begin
            done_q <= 1'b1;
            state  <= ST_IDLE;
          end else begin
            beats     <= plan_beats;
            arvalid_q <= 1'b1;
            state     <= ST_RD_ADDR;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign done = done_q;
  assign err  = err_q;

  assign m.arvalid  = arvalid_q;
  assign m.araddr   = src;
  assign m.arlen    = 8'(beats - 9'd1);
  assign m.arsize   = 3'(SIZE_LOG2);
  assign m.arburst  = BURST_INCR;
  assign m.arid     = '0;
  assign m.arprot   = '0;
  assign m.arcache  = '0;
  assign m.arqos    = '0;
  assign m.arregion = '0;
  assign m.aruser   = 1'b0;
  assign m.rready   = rready_q;

  assign m.awvalid  = awvalid_q;
  assign m.awaddr   = dest;
  assign m.awlen    = 8'(beats - 9'd1);
  assign m.awsize   = 3'(SIZE_LOG2);
  assign m.awburst  = BURST_INCR;
  assign m.awid     = '0;
  assign m.awprot   = '0;
  assign m.awcache  = '0;
  assign m.awqos    = '0;
  assign m.awregion = '0;
  assign m.awuser   = 1'b0;

  assign m.wvalid   = wvalid;
  assign m.wdata    = fifo_dout;
  assign m.wstrb    = '1;
  assign m.wlast    = wlast;
  assign m.wuser    = 1'b0;
  assign m.bready   = bready_q;
endmodule
